// File: rtl/svo_testpat_if.sv
// AXI4-Stream pixel link used by svo_testpat: 24-bit {B,G,R} pixels with
// tuser marking pixel (0,0) of each frame.
interface svo_testpat_if;
    logic        tvalid;
    logic        tready;
    logic [23:0] tdata;
    logic        tuser;

    modport master (
        output tvalid,
        output tdata,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/svo_testpat.sv
// svo_testpat: video test-pattern source for the SVO pipeline.
// Emits H_ACTIVE x V_ACTIVE frames of colour bars, grey ramp, checkerboard,
// moving line or black, selected by pattern. Enable and pattern take effect
// only at frame boundaries, so frames are never truncated.
// Optional feature: define SVO_TESTPAT_CROSSHAIR_EN to overlay a white
// crosshair at column H_ACTIVE/2 and row V_ACTIVE/2.
module svo_testpat #(
    parameter int H_ACTIVE           = 640,
    parameter int V_ACTIVE           = 480,
    parameter int SVO_BITS_PER_PIXEL = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           pattern,
    svo_testpat_if.master        out_axis,
    output logic [15:0]          frame_count
);

    localparam int          XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int          YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                          state;
    logic                            en_q;
    logic [2:0]                      pat_q;
    logic [XW-1:0]                   x;
    logic [YW-1:0]                   y;
    logic [XW-1:0]                   line_pos;

    logic                            hs;
    logic                            x_last;
    logic                            y_last;
    logic                            frame_end;
    logic [XW-1:0]                   nx;
    logic [YW-1:0]                   ny;
    logic [XW-1:0]                   lp_inc;

    logic [XW-1:0]                   px;
    logic [YW-1:0]                   py;
    logic [2:0]                      pp;
    logic [XW-1:0]                   pl;
    logic [2:0]                      bar;
    logic                            chk_x;
    logic                            chk_y;
    logic [SVO_BITS_PER_PIXEL-1:0]   pix_next;

    // Next raster position and frame-end detection for the current beat.
    always_comb begin
        hs        = out_axis.tvalid && out_axis.tready;
        x_last    = (x == XW'(H_ACTIVE - 1));
        y_last    = (y == YW'(V_ACTIVE - 1));
        frame_end = hs && x_last && y_last;
        nx        = x_last ? '0 : x + 1'b1;
        ny        = y;
        if (x_last) begin
            ny = y_last ? '0 : y + 1'b1;
        end
        lp_inc    = (line_pos == XW'(H_ACTIVE - 1)) ? '0 : line_pos + 1'b1;
    end

    // Pixel for the next beat. At frame end the freshly sampled pattern and
    // advanced line position apply, so the first pixel of the new frame
    // already reflects them; from IDLE the first beat is always (0,0).
    always_comb begin
        px = (state == RUN) ? nx : '0;
        py = (state == RUN) ? ny : '0;
        pp = frame_end ? pattern : pat_q;
        pl = frame_end ? lp_inc  : line_pos;

        bar = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (32'(px) >= k * BAR_W) begin
                bar = 3'(k);
            end
        end

        chk_x = (32'(px) & 32'h20) != 32'd0;
        chk_y = (32'(py) & 32'h20) != 32'd0;

        pix_next = '0;
        case (pp)
            // Bar order white..black maps to: R absent when bar[1], G absent
            // when bar[2], B absent when bar[0]; packing is {B,G,R}.
            3'd0:    pix_next = {{8{~bar[0]}}, {8{~bar[2]}}, {8{~bar[1]}}};
            3'd1:    pix_next = {3{8'(px)}};
            3'd2:    pix_next = (chk_x ^ chk_y) ? '1 : '0;
            3'd3:    pix_next = (px == pl) ? '1 : '0;
            default: pix_next = '0;
        endcase

`ifdef SVO_TESTPAT_CROSSHAIR_EN
        if (px == XW'(H_ACTIVE / 2) || py == YW'(V_ACTIVE / 2)) begin
            pix_next = '1;
        end
`endif
    end

    // Control FSM with raster counters and registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            en_q            <= 1'b0;
            pat_q           <= '0;
            x               <= '0;
            y               <= '0;
            line_pos        <= '0;
            frame_count     <= '0;
            out_axis.tvalid <= 1'b0;
            out_axis.tuser  <= 1'b0;
            out_axis.tdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // pat_q is held on the launch edge so the first beat and
                    // the rest of the frame use the same pattern.
                    if (en_q) begin
                        state           <= RUN;
                        en_q            <= 1'b0;
                        out_axis.tvalid <= 1'b1;
                        out_axis.tuser  <= 1'b1;
                        out_axis.tdata  <= pix_next;
                    end else begin
                        en_q  <= enable;
                        pat_q <= pattern;
                    end
                end
                RUN: begin
                    if (hs) begin
                        x              <= nx;
                        y              <= ny;
                        out_axis.tdata <= pix_next;
                        out_axis.tuser <= frame_end;
                        if (frame_end) begin
                            frame_count <= frame_count + 16'd1;
                            line_pos    <= lp_inc;
                            pat_q       <= pattern;
                            if (!enable) begin
                                state           <= IDLE;
                                out_axis.tvalid <= 1'b0;
                                out_axis.tuser  <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_svo_testpat.sv
// Testbench for svo_testpat on a reduced 64x36 raster; every visible beat is
// compared with a behavioural pixel model derived from the pattern rules.
module tb_svo_testpat;

    localparam int H = 64;
    localparam int V = 36;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  pattern;
    logic [15:0] frame_count;

    svo_testpat_if axis ();

    svo_testpat #(
        .H_ACTIVE           (H),
        .V_ACTIVE           (V),
        .SVO_BITS_PER_PIXEL (24)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern     (pattern),
        .out_axis    (axis),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mx, my, mpat, mlp;
    logic [15:0] mfc;
    bit          running;
    bit          rand_ready;
    int          hs_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_pix(input int px, input int py, input int p, input int lp);
        logic [23:0] c;
        case (p)
            0: begin
                case (px / (H / 8))
                    0:       c = 24'hFFFFFF;
                    1:       c = 24'h00FFFF;
                    2:       c = 24'hFFFF00;
                    3:       c = 24'h00FF00;
                    4:       c = 24'hFF00FF;
                    5:       c = 24'h0000FF;
                    6:       c = 24'hFF0000;
                    default: c = 24'h000000;
                endcase
            end
            1:       c = {3{8'(px % 256)}};
            2:       c = (((px / 32) % 2) != ((py / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            3:       c = (px == lp) ? 24'hFFFFFF : 24'h000000;
            default: c = 24'h000000;
        endcase
`ifdef SVO_TESTPAT_CROSSHAIR_EN
        if (px == H / 2 || py == V / 2) c = 24'hFFFFFF;
`endif
        return c;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mpat = 0; mlp = 0; mfc = 16'd0; running = 1'b0;
    endtask

    // One clock: check visible outputs against the model, then advance it.
    task automatic tick();
        bit hs, fe, en, was_valid;
        int pt;
        if (rand_ready) axis.tready = 1'($urandom_range(0, 1));
        was_valid = axis.tvalid;
        if (running) chk("tvalid_in_frame", 32'(axis.tvalid), 32'd1);
        if (axis.tvalid) begin
            chk("tdata", 32'(axis.tdata), 32'(ref_pix(mx, my, mpat, mlp)));
            chk("tuser", 32'(axis.tuser), 32'(mx == 0 && my == 0));
        end
        chk("frame_count", 32'(frame_count), 32'(mfc));
        hs = axis.tvalid && axis.tready;
        fe = hs && mx == H - 1 && my == V - 1;
        en = enable;
        pt = int'(pattern);
        @(posedge clk);
        #1;
        if (!was_valid) mpat = pt;
        if (hs) begin
            hs_total++;
            if (mx == H - 1) begin
                mx = 0;
                my = (my == V - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        if (fe) begin
            mfc++;
            mlp = (mlp + 1) % H;
            mpat = pt;
            running = en;
            if (!en) chk("tvalid_drop_after_frame", 32'(axis.tvalid), 32'd0);
        end else if (was_valid) begin
            running = 1'b1;
        end
    endtask

    task automatic run_to(input int tx, input int ty);
        int budget = 8 * N;
        while (!(axis.tvalid && mx == tx && my == ty) && budget > 0) begin
            tick();
            budget--;
        end
        chk("run_to_reached", 32'(budget > 0), 32'd1);
    endtask

    task automatic run_frame();
        logic [15:0] start = mfc;
        int budget = 8 * N;
        while (mfc == start && budget > 0) begin
            tick();
            budget--;
        end
        chk("frame_end_reached", 32'(budget > 0), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("rst_tuser", 32'(axis.tuser), 32'd0);
        chk("rst_tdata", 32'(axis.tdata), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
    endtask

    initial begin
        int base;
        reset       = 1'b1;
        enable      = 1'b1;
        pattern     = 3'd0;
        axis.tready = 1'b1;
        rand_ready  = 1'b0;
        hs_total    = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // Start-up latency, colour bars, beats per frame.
        do_reset();
        tick();
        chk("first_edge_tvalid", 32'(axis.tvalid), 32'd0);
        tick();
        chk("second_edge_tvalid", 32'(axis.tvalid), 32'd1);
        chk("first_beat_tdata", 32'(axis.tdata), 32'h00FFFFFF);
        chk("first_beat_tuser", 32'(axis.tuser), 32'd1);
        run_to(H / 8, 0);
        chk("bar1_yellow", 32'(axis.tdata), 32'h0000FFFF);
        run_to(H - 1, 0);
        chk("last_col_black", 32'(axis.tdata), 32'h0);
        run_frame();
        base = hs_total;
        run_frame();
        chk("beats_per_frame", 32'(hs_total - base), 32'(N));
        chk("tuser_next_frame", 32'(axis.tuser), 32'd1);

        // Random backpressure over two frames (second one grey ramp).
        pattern    = 3'd1;
        rand_ready = 1'b1;
        run_frame();
        pattern    = 3'd0;
        run_frame();
        rand_ready  = 1'b0;
        axis.tready = 1'b1;

        // Pattern change mid-frame applies only from the next frame.
        run_to(10, 10);
        pattern = 3'd2;
        run_frame();
        chk("pat2_origin_black", 32'(axis.tdata), 32'h0);
        run_to(32, 0);
        chk("pat2_32_0_white", 32'(axis.tdata), 32'h00FFFFFF);

        // Moving line from reset: column tracks the frame number.
        pattern = 3'd3;
        do_reset();
        tick();
        tick();
        for (int f = 0; f < 3; f++) begin
            run_to(f, 5);
            chk("line_white", 32'(axis.tdata), 32'h00FFFFFF);
            run_to(f + 1, 5);
            chk("line_next_black", 32'(axis.tdata), 32'h0);
            run_frame();
            chk("line_frame_count", 32'(frame_count), 32'(f + 1));
        end

        // Enable dropped mid-frame, then re-asserted.
        pattern = 3'd0;
        run_to(20, 10);
        enable = 1'b0;
        run_frame();
        repeat (5) tick();
        chk("idle_tvalid", 32'(axis.tvalid), 32'd0);
        enable = 1'b1;
        tick();
        chk("resume_sample_edge", 32'(axis.tvalid), 32'd0);
        tick();
        chk("resume_tvalid", 32'(axis.tvalid), 32'd1);
        chk("resume_tuser", 32'(axis.tuser), 32'd1);

        // Reset in the middle of a frame.
        run_to(30, 20);
        do_reset();
        tick();
        tick();
        chk("post_reset_tvalid", 32'(axis.tvalid), 32'd1);
        chk("post_reset_tuser", 32'(axis.tuser), 32'd1);
        chk("post_reset_frame_count", 32'(frame_count), 32'd0);

        // frame_count wrap from 16'hFFFF.
        run_to(5, 3);
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        mfc = 16'hFFFF;
        run_frame();
        chk("frame_count_wrap", 32'(frame_count), 32'd0);

        // Pattern 4 is black; crosshair overlays it when enabled.
        pattern = 3'd4;
        run_frame();
        run_to(3, 5);
        chk("pat4_black", 32'(axis.tdata), 32'h0);
        run_to(H / 2, 5);
`ifdef SVO_TESTPAT_CROSSHAIR_EN
        chk("crosshair_col", 32'(axis.tdata), 32'h00FFFFFF);
`else
        chk("no_crosshair_col", 32'(axis.tdata), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/svo_testpat.md
# svo_testpat

Video test-pattern source for the SVO pipeline. Generates an AXI4-Stream pixel stream in the format `svo_vdma` emits, with `tuser[0]` marking start of frame. It plugs into the `in_axis` input of `svo_overlay`, or directly into `svo_enc`, in place of `svo_vdma`. This lets the HDMI path (enc → tmds → serdes) be brought up and checked without DDR or AXI configuration.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line, ≥ 8, multiple of 8.
- `V_ACTIVE`, 480: active lines per frame, ≥ 2.
- `SVO_BITS_PER_PIXEL`, 24: pixel width, fixed at 24, packed as {B[23:16], G[15:8], R[7:0]}.

Ports:
- `clk` in 1: pixel clock; all logic is on this clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: stream enable, sampled only at frame boundaries.
- `pattern` in 3: pattern select, latched at frame start.
- `out_axis_tvalid` out 1: pixel valid.
- `out_axis_tready` in 1: downstream ready.
- `out_axis_tdata` out 24: pixel value.
- `out_axis_tuser` out 1: 1 on pixel (0,0) of each frame.
- `frame_count` out 16: count of completed frames, wraps.

## Operation
- Counters:
  - `x` counts 0..H_ACTIVE-1 and `y` counts 0..V_ACTIVE-1.
  - Both advance only on handshake (tvalid && tready).
  - `x` wraps to 0 after H_ACTIVE-1, and `y` increments on that wrap.
  - The handshake at (H_ACTIVE-1, V_ACTIVE-1) is "frame end".
- FSM states:
  - IDLE:
    - tvalid=0.
    - Every cycle, samples `enable` and `pattern` into `pat_q`.
    - Goes to RUN when enable=1.
  - RUN:
    - tvalid=1.
    - At frame end, samples `enable` and `pattern`.
    - Stays in RUN if enable=1, otherwise goes to IDLE.
- Patterns, evaluated on `pat_q`:
  - 0, colour bars: bar = x / (H_ACTIVE/8). Order is white, yellow, cyan, green, magenta, red, blue, black. Each component is 8'hFF or 8'h00.
  - 1, grey ramp: R=G=B=x[7:0].
  - 2, checkerboard: white when x[5]^y[5], else black.
  - 3, moving line: white where x == `line_pos`, else black.
  - 4–7: black (24'h000000).
- `line_pos`:
  - Increments at each frame end; wraps H_ACTIVE-1 → 0.
  - Runs for every pattern, not only pattern 3.
- `frame_count` increments at each frame end, modulo 2^16.
- `pattern` or `enable` changes mid-frame are ignored until the next frame boundary.
- Frames are never truncated.

## Timing
- Reset values: tvalid=0, tuser=0, tdata=0, frame_count=0, x=y=0, line_pos=0, FSM=IDLE, pat_q=0.
- From reset: with enable=1 held through reset, tvalid rises on the 2nd rising edge after reset deasserts (IDLE sample edge, then RUN). That first beat is pixel (0,0) with tuser=1.
- Output register:
  - tdata/tuser/tvalid are registered.
  - The next pixel is computed combinationally from the next x/y and loaded on the handshake edge.
  - Throughput is one pixel per cycle with no bubbles while tready=1, including across line and frame wraps.
- Backpressure: while tvalid=1 and tready=0, tdata/tuser stay stable and x/y/frame_count do not change.
- IDLE → RUN is gated on enable only, not on tready.
- Frame end with enable=0: tvalid drops the cycle after the final handshake.
- Reset mid-frame:
  - Takes effect on the next edge and returns all state to reset values.
  - The next frame starts at (0,0) with tuser=1.
  - Downstream is expected to resync on tuser.

## Configuration
- `SVO_TESTPAT_CROSSHAIR_EN` defined:
  - Pixels with x == H_ACTIVE/2 or y == V_ACTIVE/2 are forced to white (24'hFFFFFF) on top of the selected pattern, including patterns 4–7.
  - This adds one comparator pair in the tdata path and no extra latency.
- Undefined: no crosshair; tdata is exactly the selected pattern.

## Test plan
- Reset release, enable=1, pattern=0, tready=1:
  - tvalid=1 on the 2nd edge after reset deasserts.
  - First beat is tdata=24'hFFFFFF, tuser=1.
  - Beat x=80 is 24'h00FFFF (yellow).
  - Beat x=639 is 24'h000000.
  - Exactly 640×480 beats occur between consecutive tuser pulses.
- Random tready toggling (50%) over 2 frames: received pixel sequence matches a reference model beat-for-beat; tdata/tuser never change while tvalid && !tready.
- pattern 0→2 written at (x=100, y=10): colour bars continue to the end of that frame; the next frame beat (32,0) is 24'hFFFFFF and beat (0,0) is 24'h000000.
- pattern=3 for 3 frames: white pixel appears at x=0, x=1, x=2 in frames 0, 1, 2; frame_count reads 1, 2, 3 after each frame end.
- enable dropped mid-frame: current frame completes, tvalid=0 the cycle after frame end; re-assert enable → stream resumes at (0,0) with tuser=1.
- Reset asserted at (x=300, y=200), and a frame_count wrap check:
  - After the reset, the next beat is (0,0) with tuser=1 and frame_count=0.
  - Separately, force frame_count to 16'hFFFF, complete one frame, and check it reads 0.
  - With `SVO_TESTPAT_CROSSHAIR_EN` defined, pixel (320,5) is 24'hFFFFFF under pattern 4.
